alu_scheduler: RTL and testbench
================================

ALU_SCHEDULER -- requirements
Module: alu_scheduler

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have ports req0_valid/req1_valid  input  1  requester N holds a command.
REQ-004 SHALL have ports req0_ready/req1_ready  output  1  command accepted this cycle (valid & ready).
REQ-005 SHALL have ports reqN_op  input  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 MUL; 101-111 illegal.
REQ-006 SHALL have ports reqN_x, reqN_y  input  5  operands.
REQ-007 SHALL have port rsp_valid  output  1  response held stable until taken.
REQ-008 SHALL have port rsp_ready  input  1  consumer accepts response.
REQ-009 SHALL have ports rsp_id (output 1, requester served), rsp_f (output 10, result), rsp_cout, rsp_ovf, rsp_err (output 1 each).

Function
REQ-010 SHALL implement FSM states IDLE, EXEC, MUL, RESP.
REQ-011 SHALL in IDLE grant round-robin: one valid requester wins; both valid -> requester not granted last; reqN_ready combinational, high only in IDLE for the granted requester.
REQ-012 SHALL on acceptance latch id, op, x, y and go IDLE->EXEC (op 000-011 or illegal) or IDLE->MUL (op 100).
REQ-013 SHALL in EXEC drive the internal ALU once, register result, go to RESP; rsp_valid high exactly 2 cycles after the acceptance edge.
REQ-014 SHALL compute ADD/SUB modulo 32, rsp_f = zero-extended 5-bit result, rsp_cout = carry-out (SUB: not-borrow), rsp_ovf = two's-complement 5-bit overflow; AND/OR: cout=ovf=0.
REQ-015 SHALL compute MUL unsigned 5x5->10 by shift-add, 5 MUL cycles, one multiplier bit per cycle LSB first, adding multiplicand via the ALU ADD path; rsp_valid 6 cycles after acceptance; rsp_cout=0, rsp_ovf = |rsp_f[9:5].
REQ-016 SHALL for illegal op return rsp_f=0, cout=ovf=0, rsp_err=1 with EXEC latency; rsp_err=0 otherwise.
REQ-017 SHALL in RESP hold all rsp_* stable while rsp_ready=0; on rsp_valid & rsp_ready go to IDLE, with rsp_valid low the next cycle.
REQ-018 SHALL not accept a new command before the current response is taken (one command in flight; no bypass).
REQ-019 SHALL update last-grant only on acceptance; a requester dropping valid before grant is not served.

Reset
REQ-020 SHALL on rst asynchronously enter IDLE, clear rsp_valid, rsp_f, rsp_id, rsp_cout, rsp_ovf, rsp_err, reqN_ready low while rst high, last-grant = 1 (requester 0 wins first tie).
REQ-021 SHALL on reset mid-EXEC/MUL/RESP discard the in-flight command; no response issued for it.

Structure
REQ-022 SHALL place op encodings, state encodings, widths (5, 10) and MUL iteration count (5) in shared package alu_sched_pkg.
REQ-023 SHALL instantiate one combinational sub-module alu5 (S[1:0], X, Y -> F, Cout, Overflow; 00 ADD, 01 SUB, 10 AND, 11 OR) as the only arithmetic resource.

Verification
REQ-024 SHALL test: req0 ADD x=00111 y=00111 -> rsp_f=14, cout=0, ovf=0, id=0, rsp_valid 2 cycles after accept.
REQ-025 SHALL test: req1 ADD x=01111 y=00111 -> rsp_f=22 (10110), ovf=1, cout=0; SUB x=00011 y=00001 -> rsp_f=2, cout=1, ovf=0.
REQ-026 SHALL test: MUL x=01111 y=01111 -> rsp_f=225 (0x0E1), ovf=1, rsp_valid 6 cycles after accept; MUL x=0 y=31 -> 0, ovf=0.
REQ-027 SHALL test: both requesters valid after reset, AND ops -> req0 served first, req1 second, then req0 again if still valid.
REQ-028 SHALL test: rsp_ready low 4 cycles -> rsp_* stable, both reqN_ready low; op 110 -> rsp_err=1, rsp_f=0.
REQ-029 SHALL test: rst asserted 3 cycles into MUL -> IDLE immediately, rsp_valid=0, no response after release, next command served normally.

Source files
------------

// File: rtl/alu_sched_pkg.sv
// Shared definitions for the ALU scheduler: operand/result widths, the
// command opcode encodings, the alu5 select encodings, the scheduler FSM
// states and the multiply iteration count.
package alu_sched_pkg;

  localparam int DATA_W    = 5;   // operand width
  localparam int RES_W     = 10;  // response result width (5x5 product)
  localparam int OP_W      = 3;   // command opcode width
  localparam int MUL_ITERS = 5;   // one multiplier bit per MUL cycle
  localparam int CNT_W     = 3;   // wide enough to count MUL_ITERS steps

  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_ITERS - 1);

  typedef logic [OP_W-1:0] op_t;

  localparam op_t OP_ADD = 3'b000;
  localparam op_t OP_SUB = 3'b001;
  localparam op_t OP_AND = 3'b010;
  localparam op_t OP_OR  = 3'b011;
  localparam op_t OP_MUL = 3'b100;
  // 3'b101 .. 3'b111 are illegal and answered with rsp_err

  // alu5 select: the low two opcode bits map directly onto it
  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_MUL  = 2'b10,
    ST_RESP = 2'b11
  } state_e;

  // True for the four opcodes executed directly by alu5 in EXEC
  function automatic logic is_alu_op(input op_t op);
    return (op <= OP_OR);
  endfunction

endpackage

// File: rtl/alu_scheduler_alu5.sv
// alu5 -- purely combinational 5-bit ALU, the scheduler's only arithmetic
// resource.
//   S        : operation select (00 ADD, 01 SUB, 10 AND, 11 OR)
//   X, Y     : 5-bit operands
//   F        : 5-bit result (modulo 32 for ADD/SUB)
//   Cout     : carry-out; for SUB this is not-borrow (X >= Y unsigned)
//   Overflow : two's-complement overflow for ADD/SUB, 0 for AND/OR
module alu5
  import alu_sched_pkg::*;
(
  input  alu_sel_e          S,
  input  logic [DATA_W-1:0] X,
  input  logic [DATA_W-1:0] Y,
  output logic [DATA_W-1:0] F,
  output logic              Cout,
  output logic              Overflow
);

  localparam int MSB = DATA_W - 1;

  logic [DATA_W:0] w_sum;
  logic [DATA_W:0] w_diff;

  assign w_sum  = {1'b0, X} + {1'b0, Y};
  // X - Y as X + ~Y + 1, so the top bit is the not-borrow carry
  assign w_diff = {1'b0, X} + {1'b0, ~Y} + {{DATA_W{1'b0}}, 1'b1};

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    F        = '0;
    Cout     = 1'b0;
    Overflow = 1'b0;
    case (S)
      ALU_ADD: begin
        F        = w_sum[MSB:0];
        Cout     = w_sum[DATA_W];
        Overflow = (X[MSB] == Y[MSB]) && (w_sum[MSB] != X[MSB]);
      end
      ALU_SUB: begin
        F        = w_diff[MSB:0];
        Cout     = w_diff[DATA_W];
        Overflow = (X[MSB] != Y[MSB]) && (w_diff[MSB] != X[MSB]);
      end
      ALU_AND: F = X & Y;
      ALU_OR:  F = X | Y;
      default: F = '0;
    endcase
  end

endmodule

// File: rtl/alu_scheduler.sv
// alu_scheduler -- two-requester front end for a single 5-bit ALU.
// Round-robin arbitration in IDLE accepts one command at a time; ADD, SUB,
// AND, OR and illegal opcodes take one EXEC cycle, MUL runs a 5-cycle
// shift-add through the alu5 ADD path. The response is held in RESP until
// the consumer takes it; only then is another command accepted.
//   clk, rst                 : clock, asynchronous active-high reset
//   reqN_valid / reqN_ready  : command handshake per requester (N = 0, 1)
//   reqN_op, reqN_x, reqN_y  : opcode and 5-bit operands
//   rsp_valid / rsp_ready    : response handshake
//   rsp_id                   : requester that issued the command
//   rsp_f                    : 10-bit result
//   rsp_cout, rsp_ovf        : carry-out and overflow flags
//   rsp_err                  : set for illegal opcodes
module alu_scheduler
  import alu_sched_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [DATA_W-1:0] req0_x,
  input  logic [DATA_W-1:0] req0_y,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [DATA_W-1:0] req1_x,
  input  logic [DATA_W-1:0] req1_y,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [RES_W-1:0]  rsp_f,
  output logic              rsp_cout,
  output logic              rsp_ovf,
  output logic              rsp_err
);

  state_e r_state;
  state_e w_next_state;

  // Command latched at acceptance
  logic              r_last;   // requester granted most recently
  logic              r_id;
  op_t               r_op;
  logic [DATA_W-1:0] r_x;
  logic [DATA_W-1:0] r_y;

  // Shift-add multiplier: {r_acc_hi, r_acc_lo} ends up as the product,
  // r_acc_lo starts as the multiplier and is consumed LSB first.
  logic [DATA_W-1:0] r_acc_hi;
  logic [DATA_W-1:0] r_acc_lo;
  logic [CNT_W-1:0]  r_cnt;

  logic              r_rsp_valid;
  logic              r_rsp_id;
  logic [RES_W-1:0]  r_rsp_f;
  logic              r_rsp_cout;
  logic              r_rsp_ovf;
  logic              r_rsp_err;

  logic              w_any_valid;
  logic              w_grant;
  logic              w_accept;
  op_t               w_sel_op;
  logic [DATA_W-1:0] w_sel_x;
  logic [DATA_W-1:0] w_sel_y;

  alu_sel_e          w_alu_sel;
  logic [DATA_W-1:0] w_alu_x;
  logic [DATA_W-1:0] w_alu_y;
  logic [DATA_W-1:0] w_alu_f;
  logic              w_alu_cout;
  logic              w_alu_ovf;

  logic [DATA_W-1:0] w_mul_sum;
  logic              w_mul_c;
  logic              w_mul_last;

  // --------------------------------------------------------------------
  // Arbitration: on a tie the requester not granted last wins
  // --------------------------------------------------------------------
  assign w_any_valid = req0_valid | req1_valid;
  assign w_grant     = (req0_valid && req1_valid) ? ~r_last : req1_valid;
  // rst gates acceptance so ready stays low for the whole reset pulse
  assign w_accept    = (r_state == ST_IDLE) && w_any_valid && !rst;
  assign w_sel_op    = w_grant ? req1_op : req0_op;
  assign w_sel_x     = w_grant ? req1_x  : req0_x;
  assign w_sel_y     = w_grant ? req1_y  : req0_y;

  // --------------------------------------------------------------------
  // Shared ALU: operands from the latched command in EXEC, otherwise the
  // multiplier's partial product plus multiplicand on the ADD path.
  // --------------------------------------------------------------------
  always_comb begin
    w_alu_sel = ALU_ADD;
    w_alu_x   = r_acc_hi;
    w_alu_y   = r_x;
    if (r_state == ST_EXEC) begin
      w_alu_sel = alu_sel_e'(r_op[1:0]);
      w_alu_x   = r_x;
      w_alu_y   = r_y;
    end
  end

  alu5 u_alu5 (
    .S        (w_alu_sel),
    .X        (w_alu_x),
    .Y        (w_alu_y),
    .F        (w_alu_f),
    .Cout     (w_alu_cout),
    .Overflow (w_alu_ovf)
  );

  // Multiplicand is added only when the current multiplier bit is set
  assign w_mul_sum  = r_acc_lo[0] ? w_alu_f : r_acc_hi;
  assign w_mul_c    = r_acc_lo[0] & w_alu_cout;
  assign w_mul_last = (r_cnt == MUL_LAST);

  // --------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of evaluation order.
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req0_ready = w_accept & ~w_grant;
        req1_ready = w_accept &  w_grant;
        if (w_accept) w_next_state = (w_sel_op == OP_MUL) ? ST_MUL : ST_EXEC;
      end
      ST_EXEC: w_next_state = ST_RESP;
      ST_MUL:  if (w_mul_last) w_next_state = ST_RESP;
      ST_RESP: if (rsp_ready) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the command and multiplier registers are cleared as well as
      // the visible outputs; they are tiny and a clean reset keeps an
      // aborted command from leaving stale operands behind.
      r_last      <= 1'b1;
      r_id        <= 1'b0;
      r_op        <= OP_ADD;
      r_x         <= '0;
      r_y         <= '0;
      r_acc_hi    <= '0;
      r_acc_lo    <= '0;
      r_cnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_f     <= '0;
      r_rsp_cout  <= 1'b0;
      r_rsp_ovf   <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_last   <= w_grant;
            r_id     <= w_grant;
            r_op     <= w_sel_op;
            r_x      <= w_sel_x;
            r_y      <= w_sel_y;
            r_acc_hi <= '0;
            r_acc_lo <= w_sel_y;
            r_cnt    <= '0;
          end
        end
        ST_EXEC: begin
          r_rsp_valid <= 1'b1;
          r_rsp_id    <= r_id;
          if (is_alu_op(r_op)) begin
            r_rsp_f    <= {{(RES_W-DATA_W){1'b0}}, w_alu_f};
            r_rsp_cout <= w_alu_cout;
            r_rsp_ovf  <= w_alu_ovf;
            r_rsp_err  <= 1'b0;
          end else begin
            r_rsp_f    <= '0;
            r_rsp_cout <= 1'b0;
            r_rsp_ovf  <= 1'b0;
            r_rsp_err  <= 1'b1;
          end
        end
        ST_MUL: begin
          // Shift {carry, sum, multiplier} right by one each step
          r_acc_hi <= {w_mul_c, w_mul_sum[DATA_W-1:1]};
          r_acc_lo <= {w_mul_sum[0], r_acc_lo[DATA_W-1:1]};
          r_cnt    <= r_cnt + CNT_W'(1);
          if (w_mul_last) begin
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= r_id;
            r_rsp_f     <= {w_mul_c, w_mul_sum, r_acc_lo[DATA_W-1:1]};
            r_rsp_cout  <= 1'b0;
            r_rsp_ovf   <= |{w_mul_c, w_mul_sum[DATA_W-1:1]};
            r_rsp_err   <= 1'b0;
          end
        end
        ST_RESP: begin
          if (rsp_ready) r_rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_f     = r_rsp_f;
  assign rsp_cout  = r_rsp_cout;
  assign rsp_ovf   = r_rsp_ovf;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_alu_scheduler.sv
// Self-checking bench for alu_scheduler. Expected responses come from a
// plain-arithmetic model of the command set and a round-robin rule model.
module tb_alu_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic       req0_ready, req1_ready;
  logic [2:0] req0_op, req1_op;
  logic [4:0] req0_x, req0_y, req1_x, req1_y;
  logic       rsp_valid, rsp_ready;
  logic       rsp_id, rsp_cout, rsp_ovf, rsp_err;
  logic [9:0] rsp_f;

  int total = 0;
  int bad   = 0;

  // {id, f, cout, ovf, err}
  logic [13:0] obs_vec;
  assign obs_vec = {rsp_id, rsp_f, rsp_cout, rsp_ovf, rsp_err};

  always #5 clk = ~clk;

  alu_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_x     (req0_x),
    .req0_y     (req0_y),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_x     (req1_x),
    .req1_y     (req1_y),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_f      (rsp_f),
    .rsp_cout   (rsp_cout),
    .rsp_ovf    (rsp_ovf),
    .rsp_err    (rsp_err)
  );

  // Reference model: result of one command from the instruction-set rules
  function automatic logic [13:0] expect_rsp(input bit id, input logic [2:0] op,
                                             input logic [4:0] x, input logic [4:0] y);
    int ux, uy, sx, sy, s, r;
    logic [9:0] f;
    bit c, v, e;
    ux = x; uy = y;
    sx = (ux >= 16) ? ux - 32 : ux;
    sy = (uy >= 16) ? uy - 32 : uy;
    f = '0; c = 0; v = 0; e = 0;
    case (op)
      3'd0: begin s = ux + uy; f = 10'(s % 32); c = (s >= 32); r = sx + sy; v = (r > 15) || (r < -16); end
      3'd1: begin s = ux - uy; f = 10'((s + 32) % 32); c = (ux >= uy); r = sx - sy; v = (r > 15) || (r < -16); end
      3'd2: f = 10'(ux & uy);
      3'd3: f = 10'(ux | uy);
      3'd4: begin s = ux * uy; f = 10'(s); v = (s >= 32); end
      default: e = 1;
    endcase
    return {id, f, c, v, e};
  endfunction

  function automatic int exp_latency(input logic [2:0] op);
    return (op == 3'd4) ? 6 : 2;
  endfunction

  task automatic set_req(input bit id, input bit v, input logic [2:0] op,
                         input logic [4:0] x, input logic [4:0] y);
    if (id) begin req1_valid = v; req1_op = op; req1_x = x; req1_y = y; end
    else    begin req0_valid = v; req0_op = op; req0_x = x; req0_y = y; end
  endtask

  task automatic drop_req(input bit id);
    if (id) req1_valid = 1'b0;
    else    req0_valid = 1'b0;
  endtask

  // Issue one command and wait for its response. lat counts cycles from
  // the accepting cycle (0) to the first cycle with rsp_valid high.
  task automatic run_cmd(input bit id, input logic [2:0] op, input logic [4:0] x,
                         input logic [4:0] y, output int lat, output bit ok);
    int w;
    @(negedge clk);
    set_req(id, 1'b1, op, x, y);
    #1;
    w = 0;
    while (!(id ? req1_ready : req0_ready) && w < 20) begin
      @(negedge clk); #1; w++;
    end
    ok  = id ? req1_ready : req0_ready;
    lat = 0;
    if (ok) begin
      @(posedge clk);
      @(negedge clk);
      drop_req(id);
      lat = 1;
      while (!rsp_valid && lat < 40) begin @(negedge clk); lat++; end
      ok = rsp_valid;
    end else begin
      drop_req(id);
    end
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Issue, compare latency and response against the model, take it
  task automatic do_and_check(input string name, input bit id, input logic [2:0] op,
                              input logic [4:0] x, input logic [4:0] y);
    int lat; bit ok; logic [13:0] exp;
    run_cmd(id, op, x, y, lat, ok);
    total++;
    if (!ok || lat != exp_latency(op)) begin
      bad++;
      $display("FAIL %s_latency: ok=%0d got=%0d expected=%0d", name, ok, lat, exp_latency(op));
    end
    exp = expect_rsp(id, op, x, y);
    total++;
    if (obs_vec !== exp) begin
      bad++;
      $display("FAIL %s_rsp: got id/f/c/v/e=%b expected=%b", name, obs_vec, exp);
    end
    take_rsp();
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s_valid_drop: got=%b expected=0", name, rsp_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_req(0, 1'b1, 3'd0, 5'd1, 5'd1);
    set_req(1, 1'b1, 3'd0, 5'd2, 5'd2);
    @(negedge clk); #1;
    total++;
    if ({req0_ready, req1_ready, rsp_valid, obs_vec} !== 17'd0) begin
      bad++;
      $display("FAIL reset_state: got rdy0/rdy1/valid/rsp=%b expected all 0",
               {req0_ready, req1_ready, rsp_valid, obs_vec});
    end
    drop_req(0); drop_req(1);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed_alu();
    do_and_check("add_7_7",   0, 3'd0, 5'b00111, 5'b00111);
    do_and_check("add_15_7",  1, 3'd0, 5'b01111, 5'b00111);
    do_and_check("sub_3_1",   0, 3'd1, 5'b00011, 5'b00001);
    do_and_check("sub_borrow",1, 3'd1, 5'b00001, 5'b00011);
    do_and_check("or_mix",    0, 3'd3, 5'b10100, 5'b00011);
  endtask

  task automatic test_mul();
    do_and_check("mul_15_15", 0, 3'd4, 5'b01111, 5'b01111);
    do_and_check("mul_0_31",  1, 3'd4, 5'd0, 5'd31);
    do_and_check("mul_31_31", 0, 3'd4, 5'd31, 5'd31);
  endtask

  task automatic test_round_robin();
    bit model_last, exp_g;
    int w;
    logic [4:0] xs [2];
    logic [4:0] ys [2];
    apply_reset();
    model_last = 1'b1;
    for (int i = 0; i < 2; i++) begin
      xs[i] = 5'($urandom);
      ys[i] = 5'($urandom);
    end
    @(negedge clk);
    set_req(0, 1'b1, 3'd2, xs[0], ys[0]);
    set_req(1, 1'b1, 3'd2, xs[1], ys[1]);
    #1;
    for (int k = 0; k < 3; k++) begin
      exp_g = ~model_last;
      total++;
      if ({req1_ready, req0_ready} !== (exp_g ? 2'b10 : 2'b01)) begin
        bad++;
        $display("FAIL rr_grant_%0d: got rdy1/rdy0=%b expected=%b", k,
                 {req1_ready, req0_ready}, (exp_g ? 2'b10 : 2'b01));
      end
      @(posedge clk);
      model_last = exp_g;
      @(negedge clk);
      total++;
      if ({req1_ready, req0_ready} !== 2'b00) begin
        bad++;
        $display("FAIL rr_busy_%0d: got rdy1/rdy0=%b expected=00", k, {req1_ready, req0_ready});
      end
      w = 0;
      while (!rsp_valid && w < 20) begin @(negedge clk); w++; end
      total++;
      if ({rsp_valid, rsp_id, rsp_f} !== {1'b1, exp_g, 5'b0, xs[exp_g] & ys[exp_g]}) begin
        bad++;
        $display("FAIL rr_rsp_%0d: got valid/id/f=%b expected=%b", k, {rsp_valid, rsp_id, rsp_f},
                 {1'b1, exp_g, 5'b0, xs[exp_g] & ys[exp_g]});
      end
      take_rsp();
      #1;
    end
    drop_req(0); drop_req(1);
  endtask

  task automatic test_backpressure();
    int lat; bit ok;
    logic [13:0] snap, exp;
    run_cmd(1, 3'd1, 5'd20, 5'd9, lat, ok);
    exp = expect_rsp(1, 3'd1, 5'd20, 5'd9);
    total++;
    if (!ok || obs_vec !== exp) begin
      bad++;
      $display("FAIL bp_rsp: ok=%0d got=%b expected=%b", ok, obs_vec, exp);
    end
    snap = obs_vec;
    set_req(0, 1'b1, 3'd0, 5'd1, 5'd2);
    set_req(1, 1'b1, 3'd0, 5'd3, 5'd4);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      total++;
      if ({rsp_valid, obs_vec, req0_ready, req1_ready} !== {1'b1, exp, 2'b00}) begin
        bad++;
        $display("FAIL bp_hold_%0d: got valid/rsp/rdy=%b expected=%b", c,
                 {rsp_valid, obs_vec, req0_ready, req1_ready}, {1'b1, snap, 2'b00});
      end
    end
    drop_req(0); drop_req(1);
    take_rsp();
    do_and_check("illegal_110", 0, 3'b110, 5'd13, 5'd7);
    do_and_check("illegal_111", 1, 3'b111, 5'd31, 5'd31);
  endtask

  task automatic test_random();
    bit id; logic [2:0] op; logic [4:0] x, y;
    for (int n = 0; n < 20; n++) begin
      id = 1'($urandom);
      op = 3'($urandom_range(0, 7));
      x  = 5'($urandom);
      y  = 5'($urandom);
      do_and_check($sformatf("rand%0d", n), id, op, x, y);
    end
  endtask

  task automatic test_reset_mid_mul();
    int lat, w; bit ok, seen;
    // Async reset while a response is pending clears it without a clock edge
    run_cmd(1, 3'd0, 5'd9, 5'd30, lat, ok);
    #2;
    set_req(0, 1'b1, 3'd0, 5'd1, 5'd1);
    rst = 1'b1;
    #1;
    total++;
    if (!ok || {rsp_valid, obs_vec, req0_ready} !== 16'd0) begin
      bad++;
      $display("FAIL async_rst_resp: ok=%0d got valid/rsp/rdy0=%b expected all 0", ok,
               {rsp_valid, obs_vec, req0_ready});
    end
    drop_req(0);
    @(negedge clk);
    rst = 1'b0;
    // Reset three cycles into a MUL
    @(negedge clk);
    set_req(0, 1'b1, 3'd4, 5'd31, 5'd31);
    #1;
    w = 0;
    while (!req0_ready && w < 20) begin @(negedge clk); #1; w++; end
    total++;
    if (req0_ready !== 1'b1) begin
      bad++;
      $display("FAIL mulrst_accept: got rdy0=%b expected=1", req0_ready);
    end
    @(posedge clk);
    @(negedge clk);
    drop_req(0);
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL mulrst_valid: got=%b expected=0", rsp_valid);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL mulrst_no_rsp: got stray response=%b expected=0", seen);
    end
    do_and_check("after_rst_add", 1, 3'd0, 5'd16, 5'd16);
    do_and_check("after_rst_mul", 0, 3'd4, 5'd6, 5'd5);
  endtask

  initial begin
    rst       = 1'b1;
    rsp_ready = 1'b0;
    set_req(0, 1'b0, 3'd0, 5'd0, 5'd0);
    set_req(1, 1'b0, 3'd0, 5'd0, 5'd0);
    test_reset();
    test_directed_alu();
    test_mul();
    test_round_robin();
    test_backpressure();
    test_random();
    test_reset_mid_mul();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
